// File: rtl/pixel_word_packer_pkg.sv
// pixel_word_packer_pkg
// Shared types and constants for the pixel word packer: FSM state encoding,
// the packed word width and the default frame geometry.
package pixel_word_packer_pkg;

    // Width of one packed output word, in pixels.
    localparam int WORD_W = 32;

    // Default frame geometry.
    localparam int DEF_ROWS_PER_FRAME = 32;
    localparam int DEF_MAX_WORDS      = 4;

    // Packer control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for the first SOF
        ST_PACK = 2'd1,   // accepting pixels into words
        ST_DONE = 2'd2    // frame complete, waiting for the next SOF
    } state_t;

    // Index width that never collapses to zero bits for tiny parameters.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/pixel_word_packer_if.sv
// pixel_word_packer_if
// Groups the pixel stream inputs and the packed word outputs of the packer.
// The master modport is the pixel source / word consumer side, the slave
// modport is the packer itself.
interface pixel_word_packer_if
    import pixel_word_packer_pkg::*;
#(
    parameter int ROWS_PER_FRAME = DEF_ROWS_PER_FRAME,
    parameter int MAX_WORDS      = DEF_MAX_WORDS
) ();

    localparam int IDX_W = clog2_min1(MAX_WORDS);
    localparam int ROW_W = clog2_min1(ROWS_PER_FRAME);

    // Pixel stream towards the packer
    logic              SOF;
    logic              PIX_VALID;
    logic              PIX_BIT;
    logic              EOL;

    // Packed words and status from the packer
    logic [WORD_W-1:0] WORD;
    logic              WORD_CE;
    logic [IDX_W-1:0]  WORD_IDX;
    logic [ROW_W-1:0]  ROW_IDX;
    logic              ROW_DONE;
    logic              FRAME_DONE;
    logic              OVF;

    modport master (
        output SOF, PIX_VALID, PIX_BIT, EOL,
        input  WORD, WORD_CE, WORD_IDX, ROW_IDX, ROW_DONE, FRAME_DONE, OVF
    );

    modport slave (
        input  SOF, PIX_VALID, PIX_BIT, EOL,
        output WORD, WORD_CE, WORD_IDX, ROW_IDX, ROW_DONE, FRAME_DONE, OVF
    );

endinterface

// File: rtl/pixel_word_packer_shift32.sv
// pixel_shift32
// 32-bit MSB-first pixel register. The incoming pixel is written at the bit
// addressed by the current bit count (count 0 -> bit 31), so a partially
// filled word is already left-aligned with zeros in the unused low bits.
// The merged output shows the register with the current pixel already
// applied, letting the owner capture a word in the same cycle as its last
// pixel. clear empties the register and takes priority over load.
module pixel_shift32
    import pixel_word_packer_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clear,
    input  logic              load,
    input  logic              bit_in,
    input  logic [4:0]        count,
    output logic [WORD_W-1:0] merged
);

    genvar gi;
    generate
        for (gi = 0; gi < WORD_W; gi++) begin : g_bit
            // Bit position that the gi-th register bit corresponds to.
            localparam logic [4:0] POS = 5'(WORD_W - 1 - gi);

            logic bit_reg;
            logic bit_next;

            // Overlay the incoming pixel when the count addresses this bit.
            always_comb begin
                bit_next = bit_reg;
                if (load && (count == POS)) begin
                    bit_next = bit_in;
                end
            end

            assign merged[gi] = bit_next;

            // Hold, load or clear the bit.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    bit_reg <= 1'b0;
                end else if (clear) begin
                    bit_reg <= 1'b0;
                end else begin
                    bit_reg <= bit_next;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pixel_word_packer.sv
// pixel_word_packer
// Packs a binarized pixel stream into 32-bit MSB-first words per row,
// tracks row/frame progress and flags rows that exceed MAX_WORDS words.
// Build option: define PIXEL_WORD_PACKER_INVERT_EN to invert PIX_BIT before
// packing (sources where ink is 0); padding bits remain 0 either way.
module pixel_word_packer
    import pixel_word_packer_pkg::*;
#(
    parameter int ROWS_PER_FRAME = DEF_ROWS_PER_FRAME,
    parameter int MAX_WORDS      = DEF_MAX_WORDS
) (
    input  logic               CLK,
    input  logic               RST_N,
    pixel_word_packer_if.slave bus
);

    localparam int IDX_W = clog2_min1(MAX_WORDS);
    localparam int ROW_W = clog2_min1(ROWS_PER_FRAME);
    // Word counter must be able to reach MAX_WORDS itself (overflow marker).
    localparam int CNT_W = clog2_min1(MAX_WORDS + 1);

    localparam logic [CNT_W-1:0] WORD_LIMIT = CNT_W'(MAX_WORDS);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS_PER_FRAME - 1);

    // Registered state
    state_t             state_reg;
    logic [4:0]         bit_cnt_reg;
    logic [CNT_W-1:0]   word_cnt_reg;
    logic [ROW_W-1:0]   row_idx_reg;
    logic [WORD_W-1:0]  word_reg;
    logic               word_ce_reg;
    logic [IDX_W-1:0]   word_idx_reg;
    logic               row_done_reg;
    logic               frame_done_reg;
    logic               ovf_reg;

    // Per-cycle decode
    logic               pix_eff;
    logic               in_pack;
    logic               sof_act;
    logic               eol_act;
    logic               pix_act;
    logic               accept;
    logic               drop;
    logic               full;
    logic               pending;
    logic               emit;
    logic               shift_clear;
    logic [WORD_W-1:0]  merged;

`ifdef PIXEL_WORD_PACKER_INVERT_EN
    assign pix_eff = ~bus.PIX_BIT;
`else
    assign pix_eff = bus.PIX_BIT;
`endif

    // Decode this cycle's inputs against the current state; SOF overrides
    // any pixel or EOL presented alongside it.
    always_comb begin
        in_pack     = (state_reg == ST_PACK);
        sof_act     = bus.SOF;
        eol_act     = in_pack && bus.EOL && !bus.SOF;
        pix_act     = in_pack && bus.PIX_VALID && !bus.SOF;
        accept      = pix_act && (word_cnt_reg < WORD_LIMIT);
        drop        = pix_act && (word_cnt_reg >= WORD_LIMIT);
        full        = accept && (bit_cnt_reg == 5'd31);
        pending     = accept || (bit_cnt_reg != 5'd0);
        emit        = full || (eol_act && pending);
        shift_clear = sof_act || emit || eol_act;
    end

    pixel_shift32 u_shift (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .clear  (shift_clear),
        .load   (accept),
        .bit_in (pix_eff),
        .count  (bit_cnt_reg),
        .merged (merged)
    );

    // Control FSM, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= 5'd0;
            word_cnt_reg   <= '0;
            row_idx_reg    <= '0;
            word_reg       <= '0;
            word_ce_reg    <= 1'b0;
            word_idx_reg   <= '0;
            row_done_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            word_ce_reg  <= emit;
            row_done_reg <= 1'b0;

            // WORD only changes when a new word is strobed out.
            if (emit) begin
                word_reg     <= merged;
                word_idx_reg <= word_cnt_reg[IDX_W-1:0];
            end

            if (sof_act) begin
                state_reg      <= ST_PACK;
                bit_cnt_reg    <= 5'd0;
                word_cnt_reg   <= '0;
                row_idx_reg    <= '0;
                ovf_reg        <= 1'b0;
                frame_done_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        // Pixels and EOL ignored until SOF.
                    end
                    ST_PACK: begin
                        if (drop) begin
                            ovf_reg <= 1'b1;
                        end
                        if (eol_act) begin
                            bit_cnt_reg  <= 5'd0;
                            word_cnt_reg <= '0;
                            row_done_reg <= 1'b1;
                            if (row_idx_reg == LAST_ROW) begin
                                row_idx_reg    <= '0;
                                frame_done_reg <= 1'b1;
                                state_reg      <= ST_DONE;
                            end else begin
                                row_idx_reg <= row_idx_reg + 1'b1;
                            end
                        end else if (accept) begin
                            // 31 -> 0 wrap marks a completed word.
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            if (full) begin
                                word_cnt_reg <= word_cnt_reg + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        // Frame finished; hold until SOF.
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.WORD       = word_reg;
    assign bus.WORD_CE    = word_ce_reg;
    assign bus.WORD_IDX   = word_idx_reg;
    assign bus.ROW_IDX    = row_idx_reg;
    assign bus.ROW_DONE   = row_done_reg;
    assign bus.FRAME_DONE = frame_done_reg;
    assign bus.OVF        = ovf_reg;

endmodule

// File: tb/tb_pixel_word_packer.sv
// tb_pixel_word_packer
// Table of row vectors plus hand-written corner sequences; expected
// word/row events are queued as stimulus is driven and compared when the
// packer strobes WORD_CE or ROW_DONE.
module tb_pixel_word_packer;
    import pixel_word_packer_pkg::*;

    localparam int ROWS = 2;
    localparam int MAXW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pixel_word_packer_if #(.ROWS_PER_FRAME(ROWS), .MAX_WORDS(MAXW)) bus ();

    pixel_word_packer #(.ROWS_PER_FRAME(ROWS), .MAX_WORDS(MAXW)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        has_word;
        logic [31:0] word;
        int          idx;
        logic        row_done;
        int          row_idx;
    } ev_t;

    typedef struct {
        logic [63:0] pat;
        int          npix;
        logic        eol_on_last;
        logic        eol_sep;
        int          nwords;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    ev_t         exp_q[$];
    vec_t        vt[10];
    int          n_checks  = 0;
    int          n_fail    = 0;
    logic [31:0] last_word = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Expected word value for a word holding nbits real pixels.
    function automatic logic [31:0] adj(input logic [31:0] w, input int nbits);
        logic [31:0] mask;
        mask = 32'h0;
        for (int b = 0; b < nbits && b < 32; b++) mask[31-b] = 1'b1;
`ifdef PIXEL_WORD_PACKER_INVERT_EN
        return w ^ mask;
`else
        return w & mask;
`endif
    endfunction

    task automatic push_ev(input logic hw, input logic [31:0] w, input int idx,
                           input logic rd, input int ri);
        ev_t e;
        e.has_word = hw;
        e.word     = w;
        e.idx      = idx;
        e.row_done = rd;
        e.row_idx  = ri;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin : mon
        ev_t e;
        if (rst_n && (bus.WORD_CE || bus.ROW_DONE)) begin
            $display("txn: WORD_CE=%0b WORD=0x%08h WORD_IDX=%0d ROW_DONE=%0b ROW_IDX=%0d",
                     bus.WORD_CE, bus.WORD, bus.WORD_IDX, bus.ROW_DONE, bus.ROW_IDX);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got WORD_CE=%0b ROW_DONE=%0b WORD=0x%08h, expected no event",
                         bus.WORD_CE, bus.ROW_DONE, bus.WORD);
            end else begin
                e = exp_q.pop_front();
                check("word_ce", {31'h0, bus.WORD_CE}, {31'h0, e.has_word});
                if (e.has_word) begin
                    check("word", bus.WORD, e.word);
                    check("word_idx", 32'(bus.WORD_IDX), 32'(e.idx));
                    last_word = e.word;
                end
                check("row_done", {31'h0, bus.ROW_DONE}, {31'h0, e.row_done});
                check("row_idx", 32'(bus.ROW_IDX), 32'(e.row_idx));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic b, input logic e);
        bus.PIX_VALID = 1'b1;
        bus.PIX_BIT   = b;
        bus.EOL       = e;
        tick();
        bus.PIX_VALID = 1'b0;
        bus.PIX_BIT   = 1'b0;
        bus.EOL       = 1'b0;
    endtask

    task automatic send_eol();
        bus.EOL = 1'b1;
        tick();
        bus.EOL = 1'b0;
    endtask

    task automatic send_sof();
        bus.SOF = 1'b1;
        tick();
        bus.SOF = 1'b0;
    endtask

    // Send up to 32 pixels from w, MSB first.
    task automatic send_word_pixels(input logic [31:0] w, input int n, input logic eol_last);
        for (int j = 0; j < n; j++) send_pix(w[31-j], eol_last && (j == n - 1));
    endtask

    // Let outstanding events appear, then require the queue to be empty
    // and WORD to hold the last strobed value.
    task automatic drain(input string name);
        repeat (2) tick();
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending events, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        check({name, "_word_hold"}, bus.WORD, last_word);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [63:0] p;
        int          bits;
        logic        eol_any;
        logic        rd_on_word;

        bus.SOF       = 1'b0;
        bus.PIX_VALID = 1'b0;
        bus.PIX_BIT   = 1'b0;
        bus.EOL       = 1'b0;

        vt[0] = '{64'hAAAAAAAA_00000000, 32, 1'b0, 1'b0, 1, 32'hAAAAAAAA, 32'h0};
        vt[1] = '{64'hFFFFFFFF_FF000000, 40, 1'b1, 1'b0, 2, 32'hFFFFFFFF, 32'hFF000000};
        vt[2] = '{64'h12345678_00000000, 32, 1'b1, 1'b0, 1, 32'h12345678, 32'h0};
        vt[3] = '{64'h80000000_00000000,  1, 1'b1, 1'b0, 1, 32'h80000000, 32'h0};
        vt[4] = '{64'hDEADBEEF_80000000, 33, 1'b1, 1'b0, 2, 32'hDEADBEEF, 32'h80000000};
        vt[5] = '{64'hFFFFFFFE_00000000, 31, 1'b1, 1'b0, 1, 32'hFFFFFFFE, 32'h0};
        vt[6] = '{64'hC3C3C3C3_5A5A5A5A, 64, 1'b1, 1'b0, 2, 32'hC3C3C3C3, 32'h5A5A5A5A};
        vt[7] = '{64'h00000000_00000000,  0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
        vt[8] = '{64'hF0000000_00000000,  4, 1'b0, 1'b1, 1, 32'hF0000000, 32'h0};
        vt[9] = '{64'h0F0F0F0F_00000000, 32, 1'b0, 1'b1, 1, 32'h0F0F0F0F, 32'h0};

        // Reset state
        repeat (3) tick();
        check("rst_word", bus.WORD, 32'h0);
        check("rst_word_ce", {31'h0, bus.WORD_CE}, 32'h0);
        check("rst_word_idx", 32'(bus.WORD_IDX), 32'h0);
        check("rst_row_idx", 32'(bus.ROW_IDX), 32'h0);
        check("rst_row_done", {31'h0, bus.ROW_DONE}, 32'h0);
        check("rst_frame_done", {31'h0, bus.FRAME_DONE}, 32'h0);
        check("rst_ovf", {31'h0, bus.OVF}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Table-driven rows, each started by SOF
        for (int i = 0; i < 10; i++) begin
            p       = vt[i].pat;
            eol_any = vt[i].eol_on_last || vt[i].eol_sep;
            rd_on_word = eol_any && (vt[i].nwords > 0) &&
                         (vt[i].eol_on_last || (vt[i].npix % 32 != 0));
            for (int k = 0; k < vt[i].nwords; k++) begin
                bits = vt[i].npix - 32 * k;
                if (bits > 32) bits = 32;
                push_ev(1'b1, adj((k == 0) ? vt[i].w0 : vt[i].w1, bits), k,
                        rd_on_word && (k == vt[i].nwords - 1),
                        (rd_on_word && (k == vt[i].nwords - 1)) ? 1 : 0);
            end
            if (eol_any && !rd_on_word) push_ev(1'b0, 32'h0, 0, 1'b1, 1);
            send_sof();
            for (int j = 0; j < vt[i].npix; j++) begin
                send_pix(p[63-j], vt[i].eol_on_last && (j == vt[i].npix - 1));
                repeat ($urandom_range(0, 1)) tick();
            end
            if (vt[i].eol_sep) send_eol();
            drain($sformatf("vec%0d", i));
        end

        // Overflow: 160 pixels, only four words, OVF from pixel 129 on
        for (int k = 0; k < 4; k++) push_ev(1'b1, adj(32'hAAAAAAAA, 32), k, 1'b0, 0);
        send_sof();
        for (int j = 1; j <= 160; j++) begin
            send_pix(j % 2 == 1, 1'b0);
            if (j == 128) check("ovf_at_128", {31'h0, bus.OVF}, 32'h0);
            if (j == 129) check("ovf_at_129", {31'h0, bus.OVF}, 32'h1);
        end
        push_ev(1'b0, 32'h0, 0, 1'b1, 1);
        send_eol();
        drain("ovf");
        check("ovf_sticky", {31'h0, bus.OVF}, 32'h1);
        send_sof();
        check("ovf_cleared_by_sof", {31'h0, bus.OVF}, 32'h0);

        // Frame completion with two rows, then ignored pixels until SOF
        push_ev(1'b1, adj(32'hCAFEF00D, 32), 0, 1'b1, 1);
        push_ev(1'b1, adj(32'h0000FFFF, 32), 0, 1'b1, 0);
        send_word_pixels(32'hCAFEF00D, 32, 1'b1);
        check("frame_done_row0", {31'h0, bus.FRAME_DONE}, 32'h0);
        send_word_pixels(32'h0000FFFF, 32, 1'b1);
        drain("frame");
        check("frame_done_set", {31'h0, bus.FRAME_DONE}, 32'h1);
        check("frame_row_wrap", 32'(bus.ROW_IDX), 32'h0);
        send_word_pixels(32'hFFFFFFFF, 32, 1'b0);
        send_word_pixels(32'hFFFFFFFF, 8, 1'b1);
        drain("frame_ignored");
        check("frame_done_held", {31'h0, bus.FRAME_DONE}, 32'h1);
        send_sof();
        check("frame_done_cleared", {31'h0, bus.FRAME_DONE}, 32'h0);

        // SOF together with EOL: SOF wins, partial word discarded
        send_word_pixels(32'hFFFFFFFF, 10, 1'b0);
        bus.SOF = 1'b1;
        bus.EOL = 1'b1;
        tick();
        bus.SOF = 1'b0;
        bus.EOL = 1'b0;
        check("sof_eol_row_idx", 32'(bus.ROW_IDX), 32'h0);
        push_ev(1'b1, adj(32'h13579BDF, 32), 0, 1'b0, 0);
        send_word_pixels(32'h13579BDF, 32, 1'b0);
        drain("sof_eol");

        // Asynchronous reset mid-row
        send_sof();
        send_word_pixels(32'hFFFFFFFF, 10, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_word", bus.WORD, 32'h0);
        check("midrst_word_ce", {31'h0, bus.WORD_CE}, 32'h0);
        check("midrst_row_idx", 32'(bus.ROW_IDX), 32'h0);
        check("midrst_ovf", {31'h0, bus.OVF}, 32'h0);
        last_word = 32'h0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send_word_pixels(32'hFFFFFFFF, 32, 1'b1);
        drain("idle_ignored");
        push_ev(1'b1, adj(32'h00000000, 32), 0, 1'b0, 0);
        send_sof();
        send_word_pixels(32'h00000000, 32, 1'b0);
        drain("after_rst");

        // Four zero pixels then EOL: padded word
        push_ev(1'b1, adj(32'h00000000, 4), 0, 1'b1, 1);
        send_sof();
        send_word_pixels(32'h00000000, 4, 1'b0);
        send_eol();
        drain("four_zeros");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
